// File: rtl/frame_manager_pkg.sv
// frame_manager_pkg: shared constants and types for the frame manager
package frame_manager_pkg;
  localparam int NUM_SRC = 4;
  localparam int SOURCE_SEL_ADDRW = 3;
  localparam logic [SOURCE_SEL_ADDRW-1:0] SRC_BACKGROUND = 3'd0;
  localparam logic [SOURCE_SEL_ADDRW-1:0] SRC_GSENS = 3'd1;
  localparam logic [SOURCE_SEL_ADDRW-1:0] SRC_SPRITES = 3'd2;
  localparam logic [SOURCE_SEL_ADDRW-1:0] SRC_OVERLAY = 3'd3;
  localparam logic [SOURCE_SEL_ADDRW-1:0] PARK_SEL = SOURCE_SEL_ADDRW'(NUM_SRC);
  typedef enum logic [2:0] {IDLE, SCAN, REQUEST, WAIT_START, WAIT_END, ADVANCE, DONE} sched_state_t;
endpackage

// File: rtl/draw_source_scheduler_if.sv
// draw_source_scheduler_if: shared frame-buffer write bus between scheduler and drawers
//   write_source_sel  granted source ID (park value when none)
//   write_awaited     one-cycle request strobe to the selected source
//   write_active      high while the selected source writes
interface draw_source_scheduler_if #(parameter int SEL_W = frame_manager_pkg::SOURCE_SEL_ADDRW);
  logic [SEL_W-1:0] write_source_sel;
  logic write_awaited;
  logic write_active;
  modport master(output write_source_sel, output write_awaited, input write_active);
  modport slave(input write_source_sel, input write_awaited, output write_active);
endinterface

// File: rtl/sched_timeout_counter.sv
// sched_timeout_counter: loadable down-counter that flags expiry at zero
//   load_i/load_val_i  reload the count; dec_i  step down (holds at zero)
//   expired_o          count has reached zero
module sched_timeout_counter #(parameter int W = 4) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] load_val_i,
  output logic         expired_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? load_val_i : (dec_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign expired_o = cnt_q == '0;
endmodule

// File: rtl/draw_source_scheduler.sv
// draw_source_scheduler: grants the shared write bus to each enabled draw source in ID order per frame
//   frame_start/source_enable  begin a pass with latched enables
//   bus                        select/request/active handshake to the drawers
//   busy/frame_done            pass in progress / one-cycle end pulse
//   timeout_flags              sticky per-source no-response flags
//   last_frame_cycles          saturating duration of the last pass
module draw_source_scheduler import frame_manager_pkg::*; #(
  parameter int NUM_SOURCES = NUM_SRC,
  parameter int START_TIMEOUT = 15,
  parameter int CYCLE_CNT_W = 20
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   frame_start,
  input  logic [NUM_SOURCES-1:0] source_enable,
  output logic                   busy,
  output logic                   frame_done,
  output logic [NUM_SOURCES-1:0] timeout_flags,
  output logic [CYCLE_CNT_W-1:0] last_frame_cycles,
  draw_source_scheduler_if.master bus
);
  localparam int CW = NUM_SOURCES > 1 ? $clog2(NUM_SOURCES) : 1;
  localparam int TW = START_TIMEOUT > 1 ? $clog2(START_TIMEOUT) : 1;
  localparam logic [SOURCE_SEL_ADDRW-1:0] PARK = SOURCE_SEL_ADDRW'(NUM_SOURCES);
  sched_state_t state_q, state_d;
  logic [CW-1:0] cursor_q, cursor_d;
  logic [SOURCE_SEL_ADDRW-1:0] sel_q, sel_d;
  logic [NUM_SOURCES-1:0] en_q, en_d, flags_q, flags_d;
  logic [CYCLE_CNT_W-1:0] cnt_q, cnt_d, last_q, last_d;
  logic busy_q, load, dec, expired, active, last_src;
  // an undriven (z/x) bus reads as idle
  assign active = bus.write_active === 1'b1;
  assign last_src = cursor_q == CW'(NUM_SOURCES - 1);
  sched_timeout_counter #(.W(TW)) u_tmo (
    .clk(clk), .resetN(resetN), .load_i(load), .dec_i(dec),
    .load_val_i(TW'(START_TIMEOUT - 1)), .expired_o(expired)
  );
  always_comb begin
    state_d = state_q;
    cursor_d = cursor_q;
    sel_d = sel_q;
    en_d = en_q;
    flags_d = flags_q;
    last_d = last_q;
    cnt_d = state_q == IDLE ? cnt_q : (&cnt_q ? cnt_q : cnt_q + 1'b1);
    load = 1'b0;
    dec = 1'b0;
    unique case (state_q)
      IDLE: if (frame_start) begin
        state_d = SCAN;
        en_d = source_enable;
        cursor_d = '0;
        flags_d = '0;
        cnt_d = '0;
      end
      SCAN: if (en_q[cursor_q]) begin
        state_d = REQUEST;
        sel_d = SOURCE_SEL_ADDRW'(cursor_q);
      end else if (last_src) state_d = DONE;
      else cursor_d = cursor_q + 1'b1;
      REQUEST: begin
        state_d = WAIT_START;
        load = 1'b1;
      end
      // a rise on the expiry cycle wins over the timeout
      WAIT_START: if (active) state_d = WAIT_END;
      else if (expired) begin
        flags_d[cursor_q] = 1'b1;
        state_d = ADVANCE;
        sel_d = PARK;
      end else dec = 1'b1;
      WAIT_END: if (!active) begin
        state_d = ADVANCE;
        sel_d = PARK;
      end
      ADVANCE: if (last_src) state_d = DONE;
      else begin
        cursor_d = cursor_q + 1'b1;
        state_d = SCAN;
      end
      DONE: begin
        last_d = cnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      state_q <= IDLE;
      cursor_q <= '0;
      sel_q <= PARK;
      en_q <= '0;
      flags_q <= '0;
      cnt_q <= '0;
      last_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cursor_q <= cursor_d;
      sel_q <= sel_d;
      en_q <= en_d;
      flags_q <= flags_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
      busy_q <= state_d != IDLE;
    end
  assign bus.write_source_sel = sel_q;
  assign bus.write_awaited = state_q == REQUEST;
  assign busy = busy_q;
  assign frame_done = state_q == DONE;
  assign timeout_flags = flags_q;
  assign last_frame_cycles = last_q;
endmodule

// File: tb/tb_draw_source_scheduler.sv
// tb_draw_source_scheduler: scoreboard bench for draw_source_scheduler with stub drawers
module tb_draw_source_scheduler;
  import frame_manager_pkg::*;
  typedef struct {logic [3:0] flags; int cyc; int park;} done_t;
  logic clk = 1'b0;
  logic resetN, frame_start, busy, frame_done;
  logic [3:0] source_enable, timeout_flags, hold;
  logic [19:0] last_frame_cycles;
  logic [7:0] respond;
  logic [1:0] dly;
  logic [2:0] sel_q[$];
  done_t done_q[$];
  logic [2:0] cur;
  int n_chk = 0, n_err = 0, done_cnt = 0, park_cnt = 0, exp_cyc = 0, lat, n0, found;
  bit cyc_pend = 0;
  draw_source_scheduler_if bus();
  draw_source_scheduler dut (
    .clk(clk), .resetN(resetN), .frame_start(frame_start), .source_enable(source_enable),
    .busy(busy), .frame_done(frame_done), .timeout_flags(timeout_flags),
    .last_frame_cycles(last_frame_cycles), .bus(bus)
  );
  always #5 clk = ~clk;
  // stub drawer: raises write_active 2 cycles after the request, holds it 8 cycles
  always @(posedge clk or negedge resetN)
    if (!resetN) begin
      dly <= 2'd0;
      hold <= 4'd0;
    end else if (bus.write_awaited && respond[bus.write_source_sel]) dly <= 2'd1;
    else if (dly != 2'd0) begin
      dly <= dly - 2'd1;
      if (dly == 2'd1) hold <= 4'd8;
    end else if (hold != 4'd0) hold <= hold - 4'd1;
  assign bus.write_active = hold != 4'd0;
  task automatic check(input string n, input int a, input int e);
    n_chk++;
    if (a != e) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", n, a, e);
    end
  endtask
  always @(negedge clk) begin
    if (!resetN) park_cnt = 0;
    else begin
      if (cyc_pend) begin
        check("last_frame_cycles", int'(last_frame_cycles), exp_cyc);
        cyc_pend = 0;
      end
      if (busy && bus.write_source_sel == PARK_SEL) park_cnt++;
      if (bus.write_awaited) begin
        if (sel_q.size() == 0) check("unexpected_awaited", int'(bus.write_source_sel), -1);
        else begin
          cur = sel_q.pop_front();
          check("request_sel", int'(bus.write_source_sel), int'(cur));
        end
      end else if (busy && bus.write_source_sel != PARK_SEL)
        check("sel_stable", int'(bus.write_source_sel), int'(cur));
      if (frame_done) begin
        done_t d;
        done_cnt++;
        if (done_q.size() == 0) check("unexpected_done", 1, 0);
        else begin
          d = done_q.pop_front();
          check("timeout_flags", int'(timeout_flags), int'(d.flags));
          check("park_cycles", park_cnt, d.park);
          check("sel_parked_done", int'(bus.write_source_sel), int'(PARK_SEL));
          exp_cyc = d.cyc;
          cyc_pend = 1;
        end
        park_cnt = 0;
      end
    end
  end
  task automatic run_frame(input logic [3:0] en, input logic [3:0] rsp, input logic [3:0] fl,
                           input int cyc, input int park, output int l);
    for (int i = 0; i < 4; i++) if (en[i]) sel_q.push_back(3'(i));
    done_q.push_back('{fl, cyc, park});
    source_enable = en;
    respond = {4'h0, rsp};
    frame_start = 1'b1;
    l = 0;
    do begin
      @(negedge clk);
      if (l == 0) frame_start = 1'b0;
      l++;
    end while (!frame_done && l < 400);
    check("frame_done_seen", int'(frame_done), 1);
    repeat (3) @(negedge clk);
    check("requests_left", sel_q.size(), 0);
  endtask
  task automatic check_reset_values();
    check("rst_sel", int'(bus.write_source_sel), int'(PARK_SEL));
    check("rst_awaited", int'(bus.write_awaited), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(frame_done), 0);
    check("rst_flags", int'(timeout_flags), 0);
    check("rst_cycles", int'(last_frame_cycles), 0);
  endtask
  initial begin
    resetN = 1'b0;
    frame_start = 1'b0;
    source_enable = 4'h0;
    respond = 8'h0;
    #12;
    check_reset_values();
    @(negedge clk) resetN = 1'b1;
    @(negedge clk);
    run_frame(4'hF, 4'hF, 4'h0, 52, 9, lat);
    run_frame(4'b0101, 4'hF, 4'h0, 28, 7, lat);
    run_frame(4'hF, 4'b1101, 4'b0010, 57, 9, lat);
    check("flags_sticky", int'(timeout_flags), 2);
    run_frame(4'h0, 4'hF, 4'h0, 4, 5, lat);
    check("empty_latency", lat, 5);
    n0 = done_cnt;
    fork
      run_frame(4'hF, 4'hF, 4'h0, 52, 9, lat);
      begin
        found = 0;
        for (int k = 0; k < 300 && found == 0; k++) begin
          @(negedge clk);
          if (bus.write_source_sel == 3'd1 && bus.write_active) found = 1;
        end
        check("reach_src1", found, 1);
        @(negedge clk) frame_start = 1'b1;
        @(negedge clk) frame_start = 1'b0;
      end
    join
    repeat (5) @(negedge clk);
    check("single_done", done_cnt - n0, 1);
    for (int i = 0; i < 4; i++) sel_q.push_back(3'(i));
    done_q.push_back('{4'h0, 52, 9});
    source_enable = 4'hF;
    respond = 8'h0F;
    frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    found = 0;
    for (int k = 0; k < 300 && found == 0; k++) begin
      @(negedge clk);
      if (bus.write_source_sel == 3'd2 && bus.write_active) found = 1;
    end
    check("reach_src2", found, 1);
    #3 resetN = 1'b0;
    #1 check_reset_values();
    sel_q.delete();
    done_q.delete();
    cyc_pend = 0;
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    run_frame(4'hF, 4'hF, 4'h0, 52, 9, lat);
    check("done_left", done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/draw_source_scheduler.md
Name: draw_source_scheduler

Overview:
- Sequences all draw sources that share the frame-buffer write bus (write_source_sel / write_awaited / write_active).
- On each frame_start it grants the bus to every enabled source, one at a time, in ascending SOURCE_ID order; higher IDs draw on top.
- Parks the select on an unused ID when idle so no source drives the bus.
- Sits in the frame manager, between the buffer-swap logic and the drawer modules.

Parameters:
- NUM_SOURCES, 4, number of draw sources (IDs 0..NUM_SOURCES-1); SOURCE_SEL_ADDRW must satisfy 2^SOURCE_SEL_ADDRW > NUM_SOURCES.
- START_TIMEOUT, 15, cycles to wait for write_active to rise after a request before the source is skipped.
- CYCLE_CNT_W, 20, width of the frame-duration counter.

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse: begin a draw pass
- source_enable  in  NUM_SOURCES  per-source enable, latched at frame_start
- write_active  in  1  shared bus; high while the selected source writes; z/x is treated as 0
- write_source_sel  out  SOURCE_SEL_ADDRW  ID of the granted source; PARK_SEL = NUM_SOURCES when none is granted
- write_awaited  out  1  one-cycle request strobe to the selected source
- busy  out  1  high from the cycle after frame_start until frame_done
- frame_done  out  1  one-cycle pulse at end of pass
- timeout_flags  out  NUM_SOURCES  sticky per-source no-response flags; cleared at the next accepted frame_start
- last_frame_cycles  out  CYCLE_CNT_W  duration of the last completed pass, saturating

Behaviour:
- Reset (async): state IDLE, write_source_sel=PARK_SEL, write_awaited=0, busy=0, frame_done=0, timeout_flags=0, last_frame_cycles=0, cursor=0, internal counters=0.
- States: IDLE, SCAN, REQUEST, WAIT_START, WAIT_END, ADVANCE, DONE.
- IDLE: frame_start=1 -> SCAN; latch en_q=source_enable; cursor=0; clear timeout_flags; frame counter=0.
- frame_start while not IDLE is ignored, with no effect on state or flags.
- SCAN:
  - en_q[cursor]=1 -> REQUEST; write_source_sel=cursor, registered.
  - Else, cursor==NUM_SOURCES-1 -> DONE.
  - Else cursor+1, stay in SCAN. Each skipped source costs one cycle.
- REQUEST: write_awaited=1 for exactly this cycle -> WAIT_START; wait counter=0.
- WAIT_START:
  - write_active=1 -> WAIT_END.
  - Else, wait counter==START_TIMEOUT-1 -> set timeout_flags[cursor], go to ADVANCE.
  - Else increment the wait counter.
  - A standard drawer raises write_active 2 cycles after sampling write_awaited, well inside the timeout.
- WAIT_END: write_active=0 -> ADVANCE. No limit on write length.
- ADVANCE:
  - write_source_sel=PARK_SEL for one cycle, a bus turnaround gap.
  - cursor==NUM_SOURCES-1 -> DONE; else cursor+1 -> SCAN.
- DONE: frame_done=1 for one cycle; last_frame_cycles=frame counter -> IDLE.
- Select stability: write_source_sel is stable from REQUEST through WAIT_END; it changes only in SCAN/ADVANCE/IDLE.
- busy: high in every state except IDLE, registered.
- Frame counter: increments every non-IDLE cycle; saturates at all-ones with no wrap.
- Simultaneous events:
  - frame_start arriving in the same cycle as DONE is ignored.
  - A source whose write_active rises on exactly the timeout cycle counts as responding; the rise has priority over the timeout.
- All enables 0: the pass still runs SCAN×NUM_SOURCES -> DONE; frame_done pulses after NUM_SOURCES+1 cycles.
- Reset mid-pass: immediate return to reset values, with select parked so the drawer's own reset releases the bus.
- source_enable changes mid-pass have no effect until the next frame_start.

Decomposition:
- Shared package frame_manager_pkg:
  - SOURCE_SEL_ADDRW
  - the source-ID constants: SRC_BACKGROUND=0, SRC_GSENS=1, ...
  - PARK_SEL
  - the state enum type sched_state_t
- Sub-module sched_timeout_counter: loadable down-counter with expiry flag, reused for the start timeout. The frame counter stays inline.

Test Plan:
- Enables 4'b1111, each stub drawer holds write_active for 8 cycles -> writes in order 0,1,2,3; write_awaited pulses exactly once per source; frame_done pulses once; timeout_flags=0.
- Enables 4'b0101 -> only IDs 0 and 2 selected; write_source_sel=4 (PARK) in gaps; last_frame_cycles matches the bench-computed count.
- Source 1 stub never responds -> after 15 WAIT_START cycles timeout_flags=4'b0010; source 2 is still served; flag clears on the next frame_start.
- Enables 4'b0000 -> frame_done 5 cycles after frame_start; write_awaited never asserted.
- Second frame_start during WAIT_END of source 1 -> ignored; exactly one frame_done.
- resetN low while source 2 is active -> outputs return to reset values asynchronously; the next frame_start runs a clean pass from ID 0.
